// File: rtl/mmb_burst_sram.sv
// rtl/mmb_burst_sram.sv - burst MMB slave backed by an inferred single-port RAM
// Optional burst statistics outputs are enabled by defining MMB_BURST_SRAM_STAT_EN.
module mmb_burst_sram #(
  parameter int    DWIDTH  = 16,
  parameter int    AWIDTH  = 8,
  parameter int    BWIDTH  = 4,
  parameter int    RDLAT   = 2,
  parameter string RAMTYPE = "AUTO"
) (
  input  logic              reset,
  input  logic              clk,
  input  logic [AWIDTH-1:0] s_addr,
  input  logic [BWIDTH-1:0] s_bcnt,
  input  logic              s_wreq,
  input  logic [DWIDTH-1:0] s_wdat,
  input  logic              s_rreq,
  output logic [DWIDTH-1:0] s_rdat,
  output logic              s_rval,
  output logic              s_busy,
  output logic              s_err
`ifdef MMB_BURST_SRAM_STAT_EN
  ,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_rd
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  localparam logic [BWIDTH:0]  LEN_ONE = (BWIDTH+1)'(1);
  localparam logic [RDLAT-1:0] VP_LAST = RDLAT'(1) << (RDLAT - 1);

  state_t            state;
  logic [AWIDTH-1:0] cur_addr;
  logic [BWIDTH:0]   rem;
  logic [BWIDTH:0]   req_len;
  logic              acc_w;
  logic              iss;
  logic [AWIDTH-1:0] ram_wa;
  logic [DWIDTH-1:0] ram_rd;
  logic [DWIDTH-1:0] dp [RDLAT];
  logic [RDLAT-1:0]  vp;
  logic              pipe_last;

  // A burst count of zero encodes the full 2**BWIDTH words.
  assign req_len   = (s_bcnt == '0) ? (LEN_ONE << BWIDTH) : {1'b0, s_bcnt};
  assign acc_w     = s_wreq && !s_busy && (state == S_IDLE || state == S_WRITE);
  assign ram_wa    = (state == S_IDLE) ? s_addr : cur_addr;
  assign iss       = (state == S_READ);
  assign pipe_last = (vp == VP_LAST);

  generate
    if (RAMTYPE == "AUTO") begin : g_ram
      logic [DWIDTH-1:0] mem [2**AWIDTH];
      always_ff @(posedge clk) begin
        if (acc_w) mem[ram_wa] <= s_wdat;
      end
      assign ram_rd = mem[cur_addr];
    end else begin : g_ram_typed
      (* ram_style = RAMTYPE *) logic [DWIDTH-1:0] mem [2**AWIDTH];
      always_ff @(posedge clk) begin
        if (acc_w) mem[ram_wa] <= s_wdat;
      end
      assign ram_rd = mem[cur_addr];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      s_busy   <= 1'b0;
      s_err    <= 1'b0;
      cur_addr <= '0;
      rem      <= '0;
    end else begin
      s_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (s_wreq) begin
            // Write wins over a simultaneous read; the read is flagged and dropped.
            s_err <= s_rreq;
            if (req_len != LEN_ONE) begin
              state    <= S_WRITE;
              cur_addr <= s_addr + AWIDTH'(1);
              rem      <= req_len - LEN_ONE;
            end
          end else if (s_rreq) begin
            state    <= S_READ;
            s_busy   <= 1'b1;
            cur_addr <= s_addr;
            rem      <= req_len;
          end
        end
        S_WRITE: begin
          s_err <= s_rreq;
          if (s_wreq) begin
            cur_addr <= cur_addr + AWIDTH'(1);
            rem      <= rem - LEN_ONE;
            if (rem == LEN_ONE) state <= S_IDLE;
          end
        end
        S_READ: begin
          cur_addr <= cur_addr + AWIDTH'(1);
          rem      <= rem - LEN_ONE;
          if (rem == LEN_ONE) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pipe_last) begin
            state  <= S_IDLE;
            s_busy <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          s_busy <= 1'b0;
        end
      endcase
    end
  end

  // Stage 0 captures the RAM word; later stages only advance on valid so s_rdat holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vp <= '0;
      for (int i = 0; i < RDLAT; i++) dp[i] <= '0;
    end else begin
      vp[0] <= iss;
      if (iss) dp[0] <= ram_rd;
      for (int i = 1; i < RDLAT; i++) begin
        vp[i] <= vp[i-1];
        if (vp[i-1]) dp[i] <= dp[i-1];
      end
    end
  end

  assign s_rdat = dp[RDLAT-1];
  assign s_rval = vp[RDLAT-1];

`ifdef MMB_BURST_SRAM_STAT_EN
  logic wr_done;
  logic rd_done;

  assign wr_done = acc_w && ((state == S_IDLE && req_len == LEN_ONE) ||
                             (state == S_WRITE && rem == LEN_ONE));
  assign rd_done = (state == S_DRAIN) && pipe_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_wr <= '0;
      stat_rd <= '0;
    end else begin
      if (wr_done && stat_wr != '1) stat_wr <= stat_wr + 32'd1;
      if (rd_done && stat_rd != '1) stat_rd <= stat_rd + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmb_burst_sram.sv
// tb/tb_mmb_burst_sram.sv - scoreboard bench for mmb_burst_sram
// Reference memory model plus expected-beat queue; a monitor pops on every s_rval.
module tb_mmb_burst_sram;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int BW    = 4;
  localparam int RDLAT = 2;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] s_addr = '0;
  logic [BW-1:0] s_bcnt = '0;
  logic          s_wreq = 1'b0;
  logic [DW-1:0] s_wdat = '0;
  logic          s_rreq = 1'b0;
  logic [DW-1:0] s_rdat;
  logic          s_rval;
  logic          s_busy;
  logic          s_err;
`ifdef MMB_BURST_SRAM_STAT_EN
  logic [31:0]   stat_wr;
  logic [31:0]   stat_rd;
`endif

  mmb_burst_sram #(.DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW), .RDLAT(RDLAT), .RAMTYPE("AUTO")) dut (
    .reset(reset), .clk(clk), .s_addr(s_addr), .s_bcnt(s_bcnt), .s_wreq(s_wreq),
    .s_wdat(s_wdat), .s_rreq(s_rreq), .s_rdat(s_rdat), .s_rval(s_rval),
    .s_busy(s_busy), .s_err(s_err)
`ifdef MMB_BURST_SRAM_STAT_EN
    , .stat_wr(stat_wr), .stat_rd(stat_rd)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_d = '0;
  int            checks = 0;
  int            errors = 0;
  int            err_seen = 0;
  int            err_exp = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      checks++;
      if (s_rval) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rval actual=rval data=%h expected=no rval (cycle %0d)", s_rdat, cyc);
        end else begin
          e = q.pop_front();
          if (s_rdat !== e.d || cyc != e.c) begin
            errors++;
            $display("FAIL rval_beat actual data=%h cycle=%0d expected data=%h cycle=%0d",
                     s_rdat, cyc, e.d, e.c);
          end
          last_d = e.d;
        end
      end else if (s_rdat !== last_d) begin
        errors++;
        $display("FAIL rdat_hold actual=%h expected=%h (cycle %0d)", s_rdat, last_d, cyc);
      end
      if (s_err) err_seen++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (s_busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=busy expected=idle within 200 cycles");
    end
  endtask

  task automatic write_burst(input int addr, input int bcnt, input int viol);
    int len;
    wait_idle();
    len = (bcnt == 0) ? 16 : bcnt;
    for (int k = 0; k < len; k++) begin
      s_wreq = 1'b1;
      s_addr = (k == 0) ? AW'(addr) : AW'($urandom);
      s_bcnt = (k == 0) ? BW'(bcnt) : BW'($urandom);
      s_wdat = DW'($urandom);
      s_rreq = (k == viol);
      model[(addr + k) % DEPTH] = s_wdat;
      if (k == viol) err_exp++;
      @(negedge clk);
    end
    s_wreq = 1'b0;
    s_rreq = 1'b0;
  endtask

  task automatic push_read(input int addr, input int len, input int base);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.d = model[(addr + k) % DEPTH];
      e.c = base + 1 + RDLAT + k;
      q.push_back(e);
    end
  endtask

  task automatic read_burst(input int addr, input int bcnt, input int hold);
    int len, base;
    wait_idle();
    len  = (bcnt == 0) ? 16 : bcnt;
    base = cyc;
    push_read(addr, len, base);
    s_rreq = 1'b1;
    s_addr = AW'(addr);
    s_bcnt = BW'(bcnt);
    repeat (hold) @(negedge clk);
    s_rreq = 1'b0;
    wait_idle();
    chk("busy_release_cycle", cyc, base + RDLAT + len + 1);
  endtask

  task automatic check_err();
    repeat (2) @(negedge clk);
    chk("err_pulse_count", err_seen, err_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b, base;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", s_busy, 0);
    chk("reset_rval", s_rval, 0);
    chk("reset_rdat", s_rdat, 0);
    chk("reset_err", s_err, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) write_burst(i * 16, 0, -1);

    write_burst(8'h10, 4, -1);
    read_burst(8'h10, 4, 1);
    write_burst(8'hFE, 4, -1);
    read_burst(8'hFE, 4, 1);
    read_burst(8'h20, 0, 1);

    write_burst(8'h40, 1, 0);
    check_err();
    write_burst(8'h50, 5, 2);
    check_err();
    read_burst(8'h40, 1, 1);
    read_burst(8'h50, 5, 1);

    read_burst(8'h30, 3, 3);

    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      write_burst(a, $urandom_range(0, 15), -1);
      b = ($urandom_range(0, 1) == 1) ? a : $urandom_range(0, DEPTH - 1);
      read_burst(b, $urandom_range(0, 15), 1);
    end

    wait_idle();
    base = cyc;
    push_read(8'h60, 8, base);
    s_rreq = 1'b1;
    s_addr = 8'h60;
    s_bcnt = 4'd8;
    @(negedge clk);
    s_rreq = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    q.delete();
    last_d = '0;
    #1;
    chk("midreset_rval", s_rval, 0);
    chk("midreset_busy", s_busy, 0);
    chk("midreset_rdat", s_rdat, 0);
`ifdef MMB_BURST_SRAM_STAT_EN
    chk("midreset_stat_wr", stat_wr, 0);
    chk("midreset_stat_rd", stat_rd, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    read_burst(8'h60, 8, 1);

    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("err_pulse_final", err_seen, err_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
